// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and helpers for the HI/LO iterative multiply/divide unit.
// Optional feature macro: HILO_MULDIV_FAST_MUL_EN (single-cycle multiply).
package hilo_muldiv_pkg;

    localparam int unsigned MD_ITERS = 32;
    localparam int unsigned MD_CNT_W = 5;
    localparam logic [MD_CNT_W-1:0] MD_LAST_CNT = 5'(MD_ITERS - 1);

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic [31:0] md_neg32(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] md_neg64(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

    // Magnitude of an operand; unsigned ops pass through untouched.
    function automatic logic [31:0] md_abs(input logic is_signed, input logic [31:0] v);
        return md_neg32(is_signed && v[31], v);
    endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Pipeline-side bundle of the HI/LO multiply/divide unit.
interface hilo_muldiv_if;

    // Handshake: start acts as valid and is held while stall_req is high;
    // an op is taken in the IDLE cycle with start=1 and flush=0, and its
    // result is delivered only by the one-cycle hi_we/lo_we pulse.
    logic        flush;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        stall_req;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output flush, start, op, src1, src2,
        input  stall_req, hi_we, lo_we, hi_o, lo_o
    );

    modport slave (
        input  flush, start, op, src1, src2,
        output stall_req, hi_we, lo_we, hi_o, lo_o
    );

endinterface

// File: rtl/hilo_muldiv_iter.sv
// 64-bit working register with one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on unsigned magnitudes.
module muldiv_iter
    import hilo_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic        div_mode,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [63:0] acc_next_o
);

    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic        div_q, div_d;

    logic [32:0] add_sum;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [63:0] step_val;

    always_comb begin
        // Multiply: {hi, multiplier}; add multiplicand into hi on lsb, shift right.
        add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        // Divide: {remainder, dividend}; the shifted remainder needs 33 bits.
        rem_sh  = acc_q[63:31];
        rem_ge  = (rem_sh >= {1'b0, opb_q});
        rem_sub = rem_sh[31:0] - opb_q;

        if (div_q) begin
            if (rem_ge) begin
                step_val = {rem_sub, acc_q[30:0], 1'b1};
            end else begin
                step_val = {rem_sh[31:0], acc_q[30:0], 1'b0};
            end
        end else begin
            step_val = {add_sum, acc_q[31:1]};
        end

        acc_d = acc_q;
        opb_d = opb_q;
        div_d = div_q;
        if (load) begin
            acc_d = {32'd0, opa};
            opb_d = opb;
            div_d = div_mode;
        end else if (step) begin
            acc_d = step_val;
        end
    end

    assign acc_next_o = step_val;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
            opb_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            opb_q <= opb_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO write port.
// Define HILO_MULDIV_FAST_MUL_EN for a single-cycle multiply path.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    hilo_muldiv_if.slave  bus,
    output md_state_e     dbg_state
);

    md_state_e            state_q, state_d;
    logic [MD_CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [31:0]          hi_q, hi_d;
    logic [31:0]          lo_q, lo_d;

    logic                 in_signed;
    logic [31:0]          abs_a, abs_b;
    logic                 it_load, it_step;
    logic [63:0]          it_next;
    logic                 neg_main, neg_rem;
    logic [63:0]          fixed;
`ifdef HILO_MULDIV_FAST_MUL_EN
    logic [63:0]          ext_a, ext_b, fast_prod;
`endif

    muldiv_iter u_iter (
        .clk        (clk),
        .resetn     (resetn),
        .load       (it_load),
        .step       (it_step),
        .div_mode   (md_is_div(bus.op)),
        .opa        (abs_a),
        .opb        (abs_b),
        .acc_next_o (it_next)
    );

    always_comb begin
        in_signed = md_is_signed(bus.op);
        abs_a     = md_abs(in_signed, bus.src1);
        abs_b     = md_abs(in_signed, bus.src2);
`ifdef HILO_MULDIV_FAST_MUL_EN
        ext_a     = in_signed ? {{32{bus.src1[31]}}, bus.src1} : {32'd0, bus.src1};
        ext_b     = in_signed ? {{32{bus.src2[31]}}, bus.src2} : {32'd0, bus.src2};
        fast_prod = ext_a * ext_b;
`endif

        // Sign fix applied to the value the final iteration produces.
        neg_main = md_is_signed(op_q) && (sign_a_q ^ sign_b_q);
        neg_rem  = md_is_signed(op_q) && sign_a_q;
        if (md_is_div(op_q)) begin
            fixed = {md_neg32(neg_rem, it_next[63:32]), md_neg32(neg_main, it_next[31:0])};
        end else begin
            fixed = md_neg64(neg_main, it_next);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        it_load  = 1'b0;
        it_step  = 1'b0;

        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_d     = bus.op;
                        sign_a_d = bus.src1[31];
                        sign_b_d = bus.src2[31];
                        cnt_d    = '0;
                        if (md_is_div(bus.op) && (bus.src2 == 32'd0)) begin
                            // Divide by zero: raw dividend in HI, all-ones in LO.
                            hi_d    = bus.src1;
                            lo_d    = 32'hFFFF_FFFF;
                            state_d = ST_DONE;
`ifdef HILO_MULDIV_FAST_MUL_EN
                        end else if (!md_is_div(bus.op)) begin
                            hi_d    = fast_prod[63:32];
                            lo_d    = fast_prod[31:0];
                            state_d = ST_DONE;
`endif
                        end else begin
                            it_load = 1'b1;
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    it_step = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == MD_LAST_CNT) begin
                        hi_d    = fixed[63:32];
                        lo_d    = fixed[31:0];
                        state_d = ST_DONE;
                    end
                end
                // The instruction still holding start here is the one retiring.
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        bus.stall_req = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                ST_IDLE: bus.stall_req = bus.start;
                ST_BUSY: bus.stall_req = 1'b1;
                default: bus.stall_req = 1'b0;
            endcase
        end
    end

    assign bus.hi_we = (state_q == ST_DONE) && !bus.flush;
    assign bus.lo_we = (state_q == ST_DONE) && !bus.flush;
    assign bus.hi_o  = hi_q;
    assign bus.lo_o  = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Table-driven plus randomized bench for hilo_muldiv, checked against an
// arithmetic reference model; honours HILO_MULDIV_FAST_MUL_EN latency.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    logic      clk;
    logic      resetn;
    md_state_e dbg_state;

    hilo_muldiv_if bus();

    hilo_muldiv dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[12];

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic from the operation's definition.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    return {sr[31:0], sq[31:0]};
                end
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        if (op[1] && b == 32'd0) return 1;
`ifdef HILO_MULDIV_FAST_MUL_EN
        if (!op[1]) return 1;
`endif
        return 33;
    endfunction

    // Driver + monitor: present op at C0, hold start, watch stall and the write pulse.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int lat;
        bit stall_ok, pair_ok, seen;
        lat      = exp_lat(op, b);
        stall_ok = 1'b1;
        pair_ok  = 1'b1;
        seen     = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src1  = a;
        bus.src2  = b;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            if (bus.stall_req !== (k < lat)) stall_ok = 1'b0;
            if (bus.lo_we !== bus.hi_we) pair_ok = 1'b0;
            if (bus.hi_we === 1'b1) begin
                seen = 1'b1;
                check({tag, " latency"}, 64'(k), 64'(lat));
                if (exp_q.size() > 0)
                    check({tag, " result"}, {bus.hi_o, bus.lo_o}, exp_q.pop_front());
            end
            @(posedge clk);
            #1;
            // Operands must not be re-sampled after C0.
            if (k == 0) begin
                bus.src1 = $urandom;
                bus.src2 = $urandom;
                bus.op   = 2'($urandom_range(0, 3));
            end
        end
        bus.start = 1'b0;
        check({tag, " pulse seen"}, 64'(seen), 64'd1);
        check({tag, " stall window"}, 64'(stall_ok), 64'd1);
        check({tag, " we pair"}, 64'(pair_ok), 64'd1);
    endtask

    initial begin
        int pulses;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        tbl[0]  = '{2'b10, 32'd7,          32'hFFFF_FFFE, 32'd1,          32'hFFFF_FFFD};
        tbl[1]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE,  32'h0000_0001};
        tbl[2]  = '{2'b00, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF,  32'hFFFF_FFFE};
        tbl[3]  = '{2'b11, 32'hFFFF_FFFF,  32'h10,        32'hF,          32'h0FFF_FFFF};
        tbl[4]  = '{2'b10, 32'h8000_0000,  32'd0,         32'h8000_0000,  32'hFFFF_FFFF};
        tbl[5]  = '{2'b11, 32'd100,        32'd7,         32'd2,          32'd14};
        tbl[6]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF,  32'hFFFF_FFFD};
        tbl[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,          32'h8000_0000};
        tbl[8]  = '{2'b00, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000,  32'd0};
        tbl[9]  = '{2'b11, 32'd5,          32'd0,         32'd5,          32'hFFFF_FFFF};
        tbl[10] = '{2'b01, 32'd0,          32'h1234_5678, 32'd0,          32'd0};
        tbl[11] = '{2'b10, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'hFFFF_FFFE,  32'd2};

        // Reset
        resetn   = 1'b0;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src1  = 32'd0;
        bus.src2  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", 64'(bus.stall_req), 64'd0);
        check("reset hi_we", 64'(bus.hi_we), 64'd0);
        check("reset hi_o", {bus.hi_o, bus.lo_o}, 64'd0);
        check("reset state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, issued back to back
        foreach (tbl[i]) begin
            exp_q.push_back({tbl[i].hi, tbl[i].lo});
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i));
        end

        // Flush at C10 of DIVU 100/7, then restart at C11
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.src1  = 32'd100;
        bus.src2  = 32'd7;
        pulses    = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.hi_we === 1'b1 || bus.stall_req !== 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        check("pre-flush window", 64'(pulses), 64'd0);
        check("flush stall", 64'(bus.stall_req), 64'd0);
        check("flush we", 64'(bus.hi_we | bus.lo_we), 64'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("post-flush state", 64'(dbg_state), 64'(ST_IDLE));
        exp_q.push_back({32'd2, 32'd14});
        run_op(2'b11, 32'd100, 32'd7, "after flush");

        // Asynchronous reset at C15 of a divide
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.src1  = 32'h1234_5678;
        bus.src2  = 32'd3;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        resetn    = 1'b0;
        bus.start = 1'b0;
        #1;
        check("async reset state", 64'(dbg_state), 64'(ST_IDLE));
        check("async reset outs", {bus.hi_o, bus.lo_o}, 64'd0);
        check("async reset ctl", {61'd0, bus.stall_req, bus.hi_we, bus.lo_we}, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.hi_we === 1'b1 || bus.lo_we === 1'b1) pulses++;
        end
        check("no pulse after reset", 64'(pulses), 64'd0);
        @(posedge clk);
        #1;

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            exp_q.push_back(ref_model(rop, ra, rb));
            run_op(rop, ra, rb, $sformatf("rand%0d op=%0d a=%h b=%h", n, rop, ra, rb));
        end
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
